nvdla_csb_target: RTL and testbench

- CSB responder (target) model of the NVDLA configuration space bus; the counterpart of the HWPE-side CSB initiator engine.
- Accepts CSB read/write requests, serves a small register bank, returns read data / write-complete responses, and runs a countdown "job" that raises dla_intr.
- Used as a lightweight stand-in for the NVDLA core in HWPE integration benches and in FPGA bring-up without the full accelerator.

---
 rtl/nvdla_csb_target.sv | 182 ++++++++++++++++++
 tb/tb_nvdla_csb_target.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/nvdla_csb_target.sv
// CSB responder standing in for the NVDLA core. It serves a small register
// bank over the CSB request/response channel and runs a countdown job that
// raises dla_intr_o when the count reaches zero.
module nvdla_csb_target #(
  parameter int unsigned        ADDR_W    = 16,
  parameter int unsigned        DATA_W    = 32,
  parameter int unsigned        NREGS     = 16,
  parameter int unsigned        RD_LAT    = 2,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              csb2nvdla_valid_i,
  output logic              csb2nvdla_ready_o,
  input  logic [ADDR_W-1:0] csb2nvdla_addr_i,
  input  logic [DATA_W-1:0] csb2nvdla_wdat_i,
  input  logic              csb2nvdla_write_i,
  input  logic              csb2nvdla_nposted_i,
  output logic              nvdla2csb_valid_o,
  output logic [DATA_W-1:0] nvdla2csb_data_o,
  output logic              nvdla2csb_wr_complete_o,
  output logic              dla_intr_o
);

  localparam int unsigned IDX_W = $clog2(NREGS);
  localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [DATA_W-1:0] ID_VAL  = DATA_W'(32'h4E56_444C);
  localparam logic [DATA_W-1:0] OOR_VAL = DATA_W'(32'hDEAD_BEEF);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdat;
    logic              write;
    logic              nposted;
  } csb_req_t;

  typedef enum logic {IDLE, RD_WAIT} state_e;

  csb_req_t          req;
  state_e            state_q, state_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              ready, rsp_vld, load_data;
  logic              rd_acc, wr_acc;
  logic [ADDR_W-1:0] idx_full;
  logic [IDX_W-1:0]  idx;
  logic              in_rng;
  logic [DATA_W-1:0] rd_val, hold_q, data_q;
  logic              wr_cmpl_q;

  logic [DATA_W-1:0] job_len_q, cnt_q;
  logic [DATA_W-1:0] scratch_q [NREGS];
  logic              busy_q, stat_q, mask_q;
  logic              job_start, job_done, w1c;

  assign req = '{addr: csb2nvdla_addr_i, wdat: csb2nvdla_wdat_i,
                 write: csb2nvdla_write_i, nposted: csb2nvdla_nposted_i};

  assign rd_acc = csb2nvdla_valid_i & ready & ~req.write;
  assign wr_acc = csb2nvdla_valid_i & ready &  req.write;

  // Unsigned offset from the base; wrap-around below the base is caught by
  // the explicit lower-bound compare.
  assign idx_full = req.addr - BASE_ADDR;
  assign in_rng   = (req.addr >= BASE_ADDR) && (idx_full < ADDR_W'(NREGS));
  assign idx      = idx_full[IDX_W-1:0];

  // Read mux sees pre-edge state, so busy/status reads return the old value.
  always_comb begin
    rd_val = OOR_VAL;
    if (in_rng) begin
      case (int'(idx))
        0:       rd_val = ID_VAL;
        1:       rd_val = DATA_W'(busy_q);
        2:       rd_val = job_len_q;
        3:       rd_val = DATA_W'(stat_q);
        4:       rd_val = DATA_W'(mask_q);
        default: rd_val = scratch_q[idx];
      endcase
    end
  end

  // Request FSM state and read-latency counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
    end
  end

  // Next state; the response data register is loaded on the edge that
  // enters the valid cycle so data_o holds its old value until then.
  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    ready     = 1'b0;
    rsp_vld   = 1'b0;
    load_data = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (csb2nvdla_valid_i && !req.write) begin
          state_d   = RD_WAIT;
          lat_d     = LAT_W'(RD_LAT - 1);
          load_data = (RD_LAT == 1);
        end
      end
      RD_WAIT: begin
        if (lat_q == '0) begin
          rsp_vld = 1'b1;
          state_d = IDLE;
        end else begin
          lat_d     = lat_q - LAT_W'(1);
          load_data = (lat_q == LAT_W'(1));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture read data at accept and present it on the valid cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q <= '0;
      data_q <= '0;
    end else begin
      if (rd_acc) hold_q <= rd_val;
      if (load_data) data_q <= (state_q == IDLE) ? rd_val : hold_q;
    end
  end

  // Non-posted write completion, one cycle after accept.
  always_ff @(posedge clk_i) begin
    if (rst_i) wr_cmpl_q <= 1'b0;
    else       wr_cmpl_q <= wr_acc & req.nposted;
  end

  // Plain RW registers: JOB_LEN, INTR_MASK and scratch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      job_len_q <= '0;
      mask_q    <= 1'b0;
      for (int i = 0; i < int'(NREGS); i++) scratch_q[i] <= '0;
    end else if (wr_acc && in_rng) begin
      if (int'(idx) == 2)      job_len_q      <= req.wdat;
      else if (int'(idx) == 4) mask_q         <= req.wdat[0];
      else if (int'(idx) >= 5) scratch_q[idx] <= req.wdat;
    end
  end

  assign job_start = wr_acc && in_rng && (int'(idx) == 1) && req.wdat[0] && !busy_q;
  assign job_done  = busy_q && (cnt_q == DATA_W'(1));
  assign w1c       = wr_acc && in_rng && (int'(idx) == 3) && req.wdat[0];

  // Job countdown; completion sets status and beats a same-edge clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      stat_q <= 1'b0;
    end else begin
      if (job_start) begin
        busy_q <= 1'b1;
        cnt_q  <= (job_len_q == '0) ? DATA_W'(1) : job_len_q;
      end else if (busy_q) begin
        cnt_q <= cnt_q - DATA_W'(1);
        if (job_done) busy_q <= 1'b0;
      end
      if (job_done) stat_q <= 1'b1;
      else if (w1c) stat_q <= 1'b0;
    end
  end

  assign csb2nvdla_ready_o       = ready;
  assign nvdla2csb_valid_o       = rsp_vld;
  assign nvdla2csb_data_o        = data_q;
  assign nvdla2csb_wr_complete_o = wr_cmpl_q;
  assign dla_intr_o              = stat_q & ~mask_q;

endmodule

// File: tb/tb_nvdla_csb_target.sv
// Bench for nvdla_csb_target: directed scenarios plus a random request mix,
// checked against an edge-indexed reference model of the register/job rules.
module tb_nvdla_csb_target;

  localparam int          NREGS  = 16;
  localparam int          RD_LAT = 2;
  localparam logic [15:0] BASE   = 16'h0000;
  localparam logic [31:0] ID_VAL = 32'h4E56_444C;
  localparam logic [31:0] OOR    = 32'hDEAD_BEEF;

  logic        clk = 1'b0, rst = 1'b1;
  logic        v = 1'b0, wrt = 1'b0, np = 1'b0;
  logic [15:0] addr = '0;
  logic [31:0] wdat = '0;
  logic        rdy, vld, wc, intr;
  logic [31:0] dat;

  always #5 clk = ~clk;

  nvdla_csb_target #(.ADDR_W(16), .DATA_W(32), .NREGS(NREGS), .RD_LAT(RD_LAT),
                     .BASE_ADDR(BASE)) dut (
    .clk_i(clk), .rst_i(rst),
    .csb2nvdla_valid_i(v), .csb2nvdla_ready_o(rdy),
    .csb2nvdla_addr_i(addr), .csb2nvdla_wdat_i(wdat),
    .csb2nvdla_write_i(wrt), .csb2nvdla_nposted_i(np),
    .nvdla2csb_valid_o(vld), .nvdla2csb_data_o(dat),
    .nvdla2csb_wr_complete_o(wc), .dla_intr_o(intr)
  );

  int total = 0, bad = 0;
  longint edge_n = 0;

  // Reference model: job tracked by its completion edge number.
  logic [31:0] m_regs [NREGS];
  logic [31:0] m_len, m_rd, m_last;
  bit          m_stat, m_mask, m_job;
  longint      m_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_len = '0; m_stat = 0; m_mask = 0; m_job = 0; m_done = 0; m_last = '0;
  endtask

  task automatic model_edge(input bit acc, input bit wr, input logic [15:0] a,
                            input logic [31:0] d);
    bit busy_pre, comp, clr, inr;
    int idx;
    busy_pre = m_job && (edge_n <= m_done);
    comp     = m_job && (edge_n == m_done);
    clr      = 0;
    idx      = int'(a) - int'(BASE);
    inr      = (idx >= 0) && (idx < NREGS);
    if (acc && !wr) begin
      if (!inr)          m_rd = OOR;
      else if (idx == 0) m_rd = ID_VAL;
      else if (idx == 1) m_rd = {31'b0, busy_pre};
      else if (idx == 2) m_rd = m_len;
      else if (idx == 3) m_rd = {31'b0, m_stat};
      else if (idx == 4) m_rd = {31'b0, m_mask};
      else               m_rd = m_regs[idx];
    end
    if (acc && wr && inr) begin
      if (idx == 1 && d[0] && !busy_pre) begin
        m_job  = 1;
        m_done = edge_n + ((m_len == 0) ? 64'd1 : longint'(m_len));
      end
      else if (idx == 2) m_len = d;
      else if (idx == 3) clr = d[0];
      else if (idx == 4) m_mask = d[0];
      else if (idx >= 5) m_regs[idx] = d;
    end
    if (comp) begin m_stat = 1; m_job = 0; end
    else if (clr) m_stat = 0;
  endtask

  // One clock edge: advance the model, then check per-cycle outputs.
  task automatic tick(input bit acc, input bit wr, input bit n,
                      input logic [15:0] a, input logic [31:0] d);
    @(posedge clk);
    edge_n++;
    if (rst) model_reset();
    else     model_edge(acc, wr, a, d);
    #1;
    chk("wr_cmpl", {31'b0, wc}, {31'b0, (!rst && acc && wr && n)});
    chk("intr", {31'b0, intr}, {31'b0, m_stat & ~m_mask});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, '0, '0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input bit n);
    chk("wr_rdy", {31'b0, rdy}, 32'd1);
    v = 1; wrt = 1; addr = a; wdat = d; np = n;
    tick(1, 1, n, a, d);
    v = 0;
    chk("wr_rdy_after", {31'b0, rdy}, 32'd1);
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] got);
    logic [31:0] exp;
    chk("rd_rdy", {31'b0, rdy}, 32'd1);
    v = 1; wrt = 0; addr = a; np = 0;
    tick(1, 0, 0, a, '0);
    exp = m_rd; v = 0; got = 'x;
    for (int k = 1; k <= RD_LAT; k++) begin
      if (k > 1) idle(1);
      chk("rd_wait_rdy", {31'b0, rdy}, 32'd0);
      chk("rd_vld", {31'b0, vld}, {31'b0, k == RD_LAT});
      chk("rd_data", dat, (k == RD_LAT) ? exp : m_last);
      if (k == RD_LAT) got = dat;
    end
    m_last = exp;
    idle(1);
    chk("rd_done_rdy", {31'b0, rdy}, 32'd1);
    chk("rd_done_vld", {31'b0, vld}, 32'd0);
    chk("rd_hold", dat, exp);
  endtask

  // Idle until intr rises (bounded) and return edges since the start edge.
  task automatic wait_intr(input longint start, output longint lat);
    int n = 0;
    while (!intr && n < 40) begin idle(1); n++; end
    if (!intr) chk("intr_timeout", 32'd0, 32'd1);
    lat = edge_n - start;
  endtask

  initial begin
    logic [31:0] got;
    longint st, lat;
    model_reset();
    idle(3);
    rst = 0;
    chk("rst_rdy", {31'b0, rdy}, 32'd1);
    chk("rst_vld", {31'b0, vld}, 32'd0);
    chk("rst_data", dat, 32'd0);

    rd(BASE + 0, got);  chk("id", got, ID_VAL);

    wr(BASE + 5, 32'hA5A5_0001, 1);
    rd(BASE + 5, got);  chk("np_wr", got, 32'hA5A5_0001);
    wr(BASE + 5, 32'h1234_5678, 0);
    rd(BASE + 5, got);  chk("p_wr", got, 32'h1234_5678);

    wr(BASE + 5, 32'h0000_0055, 0);
    wr(BASE + 6, 32'h0000_0066, 0);
    wr(BASE + 7, 32'h0000_0077, 0);
    rd(BASE + 5, got);  chk("b2b5", got, 32'h55);
    rd(BASE + 6, got);  chk("b2b6", got, 32'h66);
    rd(BASE + 7, got);  chk("b2b7", got, 32'h77);

    // Job with interrupt latency
    wr(BASE + 2, 32'd5, 1);
    wr(BASE + 1, 32'd1, 0);
    st = edge_n;
    rd(BASE + 1, got);  chk("busy", got, 32'd1);
    wait_intr(st, lat); chk("intr_lat", 32'(lat), 32'd5);
    wr(BASE + 3, 32'd1, 0);
    chk("w1c_intr", {31'b0, intr}, 32'd0);

    // Masked job
    wr(BASE + 4, 32'd1, 0);
    wr(BASE + 1, 32'd1, 0);
    idle(8);
    chk("masked_intr", {31'b0, intr}, 32'd0);
    rd(BASE + 3, got);  chk("masked_stat", got, 32'd1);
    wr(BASE + 4, 32'd0, 0);
    chk("unmask_intr", {31'b0, intr}, 32'd1);
    wr(BASE + 3, 32'd1, 1);

    // W1C on the completion edge: set wins
    wr(BASE + 2, 32'd4, 0);
    wr(BASE + 1, 32'd1, 1);
    idle(3);
    wr(BASE + 3, 32'd1, 0);
    rd(BASE + 3, got);  chk("set_wins", got, 32'd1);
    wr(BASE + 3, 32'd1, 0);

    // OP_EN while busy does not restart
    wr(BASE + 2, 32'd6, 0);
    wr(BASE + 1, 32'd1, 0);
    st = edge_n;
    idle(1);
    wr(BASE + 1, 32'd1, 0);
    wait_intr(st, lat); chk("restart_lat", 32'(lat), 32'd6);
    wr(BASE + 3, 32'd1, 0);

    rd(BASE + 16'(NREGS), got); chk("oor", got, OOR);

    // Random mix
    for (int i = 0; i < 250; i++) begin
      int op;
      logic [15:0] a;
      logic [31:0] d;
      op = $urandom_range(0, 3);
      a  = BASE + 16'($urandom_range(0, NREGS + 3));
      d  = (a == BASE + 2) ? 32'($urandom_range(0, 10)) : $urandom;
      if (op == 0)      idle(1);
      else if (op == 1) rd(a, got);
      else              wr(a, d, 1'($urandom_range(0, 1)));
    end

    // Reset during RD_WAIT
    wr(BASE + 2, 32'd9, 0);
    wr(BASE + 8, 32'hCAFE_0008, 0);
    v = 1; wrt = 0; addr = BASE + 8;
    tick(1, 0, 0, BASE + 8, '0);
    v = 0; rst = 1;
    idle(1);
    rst = 0;
    chk("mid_rst_rdy", {31'b0, rdy}, 32'd1);
    chk("mid_rst_vld", {31'b0, vld}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("mid_rst_novld", {31'b0, vld}, 32'd0);
    end
    chk("mid_rst_data", dat, 32'd0);
    rd(BASE + 2, got);  chk("rst_len", got, 32'd0);
    rd(BASE + 8, got);  chk("rst_scr", got, 32'd0);
    rd(BASE + 3, got);  chk("rst_stat", got, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
